// File: rtl/tube_pkg.sv
// Shared constants for the 7-segment tube driver and its register map.
package tube_pkg;

    typedef enum logic {
        ADDR_DATA = 1'b0,
        ADDR_CTRL = 1'b1
    } addr_e;

    localparam logic [31:0] DATA_RST = 32'h0000_0000;
    localparam logic [31:0] CTRL_RST = 32'h0000_00FF;

    localparam int unsigned CTRL_EN_LSB    = 0;
    localparam int unsigned CTRL_DP_LSB    = 8;
    localparam int unsigned CTRL_BLANK_BIT = 16;
    localparam int unsigned CTRL_W         = 17;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [31:0] apply_be(
        input logic [31:0] cur,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern (bit 0 = a .. bit 6 = g).
module hex_to_seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        unique case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/tube_driver.sv
// Memory-mapped 8-digit 7-segment driver: DATA/CTRL registers, prescaled scan, registered outputs.
module tube_driver
    import tube_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic [7:0]  digit_sel,
    output logic [7:0]  seg
);

    localparam int unsigned   PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [31:0]       data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        dsel_q, dsel_d;
    logic [7:0]        seg_q, seg_d;

    logic [3:0] nib;
    logic [6:0] hex_seg;
    logic [7:0] en_mask;
    logic [7:0] dp_mask;
    logic       blank;
    logic       step;

    assign en_mask = ctrl_q[CTRL_EN_LSB +: 8];
    assign dp_mask = ctrl_q[CTRL_DP_LSB +: 8];
    assign blank   = ctrl_q[CTRL_BLANK_BIT];
    assign nib     = data_q[{idx_q, 2'b00} +: 4];

    hex_to_seg u_hex (
        .hex_i (nib),
        .seg_o (hex_seg)
    );

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (WE) begin
            if (Addr == ADDR_CTRL) ctrl_d = CTRL_W'(apply_be(32'(ctrl_q), WD, BE));
            else                   data_d = apply_be(data_q, WD, BE);
        end
    end

    always_comb begin
        step  = (pre_q == PRE_LAST);
        pre_d = step ? '0 : pre_q + 1'b1;
        idx_d = step ? idx_q + 3'd1 : idx_q;
    end

    // Outputs come from the current idx/registers, so a new idx or write shows one edge later.
    always_comb begin
        dsel_d = SEG_OFF;
        seg_d  = SEG_OFF;
        if (en_mask[idx_q] && !blank) begin
            dsel_d = ~(8'd1 << idx_q);
            seg_d  = {~dp_mask[idx_q], hex_seg};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= DATA_RST;
            ctrl_q <= CTRL_W'(CTRL_RST);
            pre_q  <= '0;
            idx_q  <= '0;
            dsel_q <= SEG_OFF;
            seg_q  <= SEG_OFF;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            dsel_q <= dsel_d;
            seg_q  <= seg_d;
        end
    end

    assign RD        = (Addr == ADDR_CTRL) ? 32'(ctrl_q) : data_q;
    assign digit_sel = dsel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_tube_driver.sv
// Directed bench for tube_driver: a SCAN_DIV=4 instance and a SCAN_DIV=1 instance on shared inputs.
module tb_tube_driver;

    logic        clk;
    logic        reset_n;
    logic        Addr;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] WD;
    logic [31:0] rd, rd_f;
    logic [7:0]  dsel, dsel_f;
    logic [7:0]  segs, seg_f;

    int checks;
    int errors;
    int pc;
    logic [6:0] tbl [16];

    tube_driver #(.SCAN_DIV(4)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Addr      (Addr),
        .WE        (WE),
        .BE        (BE),
        .WD        (WD),
        .RD        (rd),
        .digit_sel (dsel),
        .seg       (segs)
    );

    tube_driver #(.SCAN_DIV(1)) u_fast (
        .clk       (clk),
        .reset_n   (reset_n),
        .Addr      (Addr),
        .WE        (WE),
        .BE        (BE),
        .WD        (WD),
        .RD        (rd_f),
        .digit_sel (dsel_f),
        .seg       (seg_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        pc++;
    endtask

    task automatic wr(input logic a, input logic [3:0] be, input logic [31:0] wd);
        Addr = a;
        BE   = be;
        WD   = wd;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        BE   = 4'h0;
    endtask

    task automatic do_reset();
        WE = 1'b0;
        BE = 4'h0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pc = 0;
    endtask

    task automatic chk_out(input string name, input logic [7:0] ed, input logic [7:0] es);
        checks++;
        if (dsel !== ed || segs !== es) begin
            errors++;
            $display("FAIL %s: digit_sel=%h seg=%h, expected digit_sel=%h seg=%h", name, dsel, segs, ed, es);
        end
    endtask

    task automatic test_reset();
        WE = 1'b0; BE = 4'h0; WD = '0; Addr = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("reset_outputs", 8'hFF, 8'hFF);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_rd_data: got %h expected %h", rd, 32'h0);
        end
        Addr = 1'b1; #1;
        checks++;
        if (rd !== 32'hFF) begin
            errors++; $display("FAIL reset_rd_ctrl: got %h expected %h", rd, 32'hFF);
        end
        Addr = 1'b0;
    endtask

    task automatic test_scan();
        do_reset();
        Addr = 1'b0;
        wr(1'b0, 4'hF, 32'h1234_5678);
        tick();
        chk_out("scan_d0", 8'hFE, 8'h80);
        checks++;
        if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL scan_rd: got %h expected %h", rd, 32'h1234_5678);
        end
        repeat (2) tick();
        chk_out("scan_d0_hold", 8'hFE, 8'h80);
        tick();
        chk_out("scan_d1", 8'hFD, 8'hF8);
        repeat (24) tick();
        chk_out("scan_d7", 8'h7F, 8'hF9);
        repeat (4) tick();
        chk_out("scan_wrap", 8'hFE, 8'h80);
    endtask

    task automatic test_async_reset();
        do_reset();
        wr(1'b0, 4'hF, 32'h1234_5678);
        repeat (21) tick();
        chk_out("pre_reset_d5", 8'hDF, 8'hB0);
        #2 reset_n = 1'b0;
        #1;
        chk_out("async_reset_out", 8'hFF, 8'hFF);
        checks++;
        if (dsel_f !== 8'hFF || seg_f !== 8'hFF) begin
            errors++; $display("FAIL async_reset_fast: digit_sel=%h seg=%h expected FF FF", dsel_f, seg_f);
        end
        Addr = 1'b0; #1;
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL async_reset_rd_data: got %h expected %h", rd, 32'h0);
        end
        Addr = 1'b1; #1;
        checks++;
        if (rd !== 32'hFF) begin
            errors++; $display("FAIL async_reset_rd_ctrl: got %h expected %h", rd, 32'hFF);
        end
        Addr = 1'b0;
    endtask

    task automatic test_byte_enable();
        do_reset();
        Addr = 1'b0;
        wr(1'b0, 4'hF, 32'h1234_5678);
        wr(1'b0, 4'b0101, 32'hAABB_CCDD);
        checks++;
        if (rd !== 32'h12BB_56DD) begin
            errors++; $display("FAIL be_rd: got %h expected %h", rd, 32'h12BB_56DD);
        end
        wr(1'b0, 4'b0000, 32'h0000_0000);
        checks++;
        if (rd !== 32'h12BB_56DD) begin
            errors++; $display("FAIL be_zero_noop: got %h expected %h", rd, 32'h12BB_56DD);
        end
        chk_out("be_digit0_d", 8'hFE, 8'hA1);
    endtask

    task automatic test_ctrl();
        do_reset();
        wr(1'b0, 4'hF, 32'h1234_5678);
        wr(1'b1, 4'b0011, 32'h0000_0105);
        Addr = 1'b1; #1;
        checks++;
        if (rd !== 32'h0000_0105) begin
            errors++; $display("FAIL ctrl_rd: got %h expected %h", rd, 32'h0000_0105);
        end
        tick();
        chk_out("ctrl_d0_dp", 8'hFE, 8'h00);
        repeat (2) tick();
        chk_out("ctrl_d1_masked", 8'hFF, 8'hFF);
        repeat (4) tick();
        chk_out("ctrl_d2_on", 8'hFB, 8'h82);
        wr(1'b1, 4'hF, 32'hFFFF_FFFF);
        checks++;
        if (rd !== 32'h0001_FFFF) begin
            errors++; $display("FAIL ctrl_reserved: got %h expected %h", rd, 32'h0001_FFFF);
        end
        tick();
        chk_out("ctrl_blank_a", 8'hFF, 8'hFF);
        repeat (2) tick();
        chk_out("ctrl_blank_b", 8'hFF, 8'hFF);
        Addr = 1'b0;
    endtask

    task automatic test_scan_div1();
        logic [7:0] ed;
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            tick();
            ed = ~(8'd1 << ((n - 1) % 8));
            checks++;
            if (dsel_f !== ed || seg_f !== 8'hC0) begin
                errors++;
                $display("FAIL div1_step%0d: digit_sel=%h seg=%h expected %h C0", n, dsel_f, seg_f, ed);
            end
        end
    endtask

    task automatic test_decode();
        logic [31:0] val;
        logic [3:0]  nib;
        int          d;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            val = (pass == 0) ? 32'h7654_3210 : 32'hFEDC_BA98;
            wr(1'b0, 4'hF, val);
            for (int k = 0; k < 8; k++) begin
                tick();
                d   = (pc - 1) % 8;
                nib = val[4*d +: 4];
                checks++;
                if (seg_f !== {1'b1, tbl[nib]} || dsel_f !== ~(8'd1 << d)) begin
                    errors++;
                    $display("FAIL decode_%h: digit_sel=%h seg=%h expected %h %h",
                             nib, dsel_f, seg_f, ~(8'd1 << d), {1'b1, tbl[nib]});
                end
            end
        end
    endtask

    task automatic test_write_on_step();
        do_reset();
        repeat (3) tick();
        wr(1'b0, 4'b0001, 32'h0000_00A0);
        chk_out("step_old_d0", 8'hFE, 8'hC0);
        tick();
        chk_out("step_new_d1", 8'hFD, 8'h88);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pc     = 0;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        test_reset();
        test_scan();
        test_async_reset();
        test_byte_enable();
        test_ctrl();
        test_scan_div1();
        test_decode();
        test_write_on_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
